breg_mp: RTL



---
 rtl/breg_pkg.sv | 18 +
 rtl/breg_init_ctrl.sv | 52 +++++
 rtl/breg_mp.sv | 98 +++++++++
 3 files changed

// File: rtl/breg_pkg.sv
// Shared types and helpers for the multi-port register bank.
// State encoding, default geometry and the read/write lane slicing offset.
package breg_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } breg_state_e;

    function automatic int lane_offset(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/breg_init_ctrl.sv
// Clear-sweep controller: walks every entry after reset, then hands the bank to normal operation.
// The sweep write is suppressed on reset edges so the array is untouched while reset is held.
module breg_init_ctrl
    import breg_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          running,
    output logic          ready
);

    breg_state_e   state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        clr_we    = 1'b0;
        if (state_q == ST_CLEAR) begin
            clr_we    = !reset;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    assign clr_addr = clr_idx_q;
    assign running  = (state_q == ST_RUN);
    assign ready    = ready_q;

endmodule

// File: rtl/breg_mp.sv
// Multi-port register bank: two prioritised write ports, NUM_RD combinational read lanes,
// optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
module breg_mp
    import breg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    localparam int AW      = $clog2(DEPTH),
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    we0,
    input  logic [AW-1:0]           wr_addr0,
    input  logic [WIDTH-1:0]        wr_data0,
    input  logic                    we1,
    input  logic [AW-1:0]           wr_addr1,
    input  logic [WIDTH-1:0]        wr_data1,
    output logic                    ready,
    output logic                    wr_conflict
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_conflict_q, wr_conflict_d;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             running;
    logic             wr0_ok, wr1_ok;

    breg_init_ctrl #(
        .DEPTH (DEPTH)
    ) u_init_ctrl (
        .clock    (clock),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .running  (running),
        .ready    (ready)
    );

    // A write to register 0 is a no-op target when it is hardwired to zero.
    assign wr0_ok = we0 && !(ZERO_REG && (wr_addr0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (wr_addr1 == '0));

    always_comb begin
        mem_d         = mem_q;
        wr_conflict_d = 1'b0;
        if (!reset) begin
            if (clr_we) begin
                mem_d[clr_addr] = '0;
            end else if (running) begin
                if (wr0_ok) mem_d[wr_addr0] = wr_data0;
                if (wr1_ok) mem_d[wr_addr1] = wr_data1;
                wr_conflict_d = wr0_ok && wr1_ok && (wr_addr0 == wr_addr1);
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    lane_addr;
        logic [WIDTH-1:0] lane_data;

        assign lane_addr = rd_addr[k*AW +: AW];

        // Port 1 is checked before port 0 so the bypass matches what will be stored.
        always_comb begin
            lane_data = mem_q[lane_addr];
            if (!running) begin
                lane_data = '0;
            end else if (ZERO_REG && (lane_addr == '0)) begin
                lane_data = '0;
            end else if (BYPASS && we1 && (wr_addr1 == lane_addr)) begin
                lane_data = wr_data1;
            end else if (BYPASS && we0 && (wr_addr0 == lane_addr)) begin
                lane_data = wr_data0;
            end
        end

        assign rd_data[lane_offset(k, WIDTH) +: WIDTH] = lane_data;
    end

endmodule
